// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared constants, width helpers and the registered status-flag bundle
// for the asymmetric synchronous FIFO and its storage RAM.
package iob_fifo_sync_asym_pkg;

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width ratio between the wider and the narrower port; always a power of 2.
  function automatic int ratio_f(input int w_data_w, input int r_data_w);
    return max_f(w_data_w, r_data_w) / min_f(w_data_w, r_data_w);
  endfunction

  // Units moved by one access on a port of width port_w.
  function automatic int port_ratio_f(input int port_w, input int w_data_w, input int r_data_w);
    return port_w / min_f(w_data_w, r_data_w);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/iob_ram_2p_asym.sv
// Synchronous dual-port RAM with independent write/read widths; storage is kept
// in narrow units and the wider port is steered across consecutive unit addresses.
module iob_ram_2p_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int MIN_W   = min_f(W_DATA_W, R_DATA_W);
  localparam int W_RATIO = port_ratio_f(W_DATA_W, W_DATA_W, R_DATA_W);
  localparam int R_RATIO = port_ratio_f(R_DATA_W, W_DATA_W, R_DATA_W);
  localparam int DEPTH   = 2 ** ADDR_W;

  logic [MIN_W-1:0]    mem_q [DEPTH];
  logic [R_DATA_W-1:0] r_data_d;
  logic [R_DATA_W-1:0] r_data_q;

  // Write lanes: lane i lands at w_addr+i, so the low lane is read out first.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < W_RATIO; i++) begin
        mem_q[w_addr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
      end
    end
  end

  always_comb begin
    r_data_d = '0;
    for (int i = 0; i < R_RATIO; i++) begin
      r_data_d[i*MIN_W +: MIN_W] = mem_q[r_addr + ADDR_W'(i)];
    end
  end

  // Output register holds its value until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
    end else if (r_en) begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Single-clock asymmetric-width FIFO: unit-granular pointers, registered levels,
// threshold flags and sticky overflow/underflow around an asymmetric 2-port RAM.
module iob_fifo_sync_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W         = 32,
  parameter int R_DATA_W         = 8,
  parameter int ADDR_W           = 4,
  parameter int ALMOST_FULL_LVL  = (2 ** ADDR_W) - ratio_f(W_DATA_W, R_DATA_W),
  parameter int ALMOST_EMPTY_LVL = ratio_f(W_DATA_W, R_DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic [W_DATA_W-1:0] data_in,
  output logic                full,
  output logic [ADDR_W:0]     level_w,
  input  logic                read_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                empty,
  output logic [ADDR_W:0]     level_r,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int PTR_W   = ADDR_W + 1;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int W_RATIO = port_ratio_f(W_DATA_W, W_DATA_W, R_DATA_W);
  localparam int R_RATIO = port_ratio_f(R_DATA_W, W_DATA_W, R_DATA_W);
  localparam int W_LOG   = $clog2(W_RATIO);
  localparam int R_LOG   = $clog2(R_RATIO);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] units_d;
  logic [PTR_W-1:0] free_d;
  logic [PTR_W-1:0] level_w_q, level_w_d;
  logic [PTR_W-1:0] level_r_q, level_r_d;
  flags_t           flags_q, flags_d;
  logic             w_acc;
  logic             r_acc;

  // Accept decisions use only the flags registered at the start of the cycle.
  assign w_acc = write_en && !flags_q.full;
  assign r_acc = read_en && !flags_q.empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_acc) begin
      wptr_d = wptr_q + PTR_W'(W_RATIO);
    end
    if (r_acc) begin
      rptr_d = rptr_q + PTR_W'(R_RATIO);
    end
  end

  // The extra pointer MSB lets units reach DEPTH without aliasing to zero.
  always_comb begin
    units_d   = wptr_d - rptr_d;
    free_d    = PTR_W'(DEPTH) - units_d;
    level_w_d = units_d >> W_LOG;
    level_r_d = units_d >> R_LOG;

    flags_d              = flags_q;
    flags_d.full         = free_d < PTR_W'(W_RATIO);
    flags_d.empty        = units_d < PTR_W'(R_RATIO);
    flags_d.almost_full  = units_d >= PTR_W'(ALMOST_FULL_LVL);
    flags_d.almost_empty = units_d <= PTR_W'(ALMOST_EMPTY_LVL);
    flags_d.overflow     = flags_q.overflow || (write_en && flags_q.full);
    flags_d.underflow    = flags_q.underflow || (read_en && flags_q.empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_w_q <= '0;
      level_r_q <= '0;
      flags_q   <= FLAGS_RST;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_w_q <= level_w_d;
      level_r_q <= level_r_d;
      flags_q   <= flags_d;
    end
  end

  iob_ram_2p_asym #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_acc),
    .w_addr (wptr_q[ADDR_W-1:0]),
    .w_data (data_in),
    .r_en   (r_acc),
    .r_addr (rptr_q[ADDR_W-1:0]),
    .r_data (data_out)
  );

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = flags_q.overflow;
  assign underflow    = flags_q.underflow;
  assign level_w      = level_w_q;
  assign level_r      = level_r_q;

endmodule
